// File: rtl/ov7670_cap_pkg.sv
// ov7670_cap_pkg: shared enums and sizing helper for the OV7670 capture front-end
package ov7670_cap_pkg;
  typedef enum logic [1:0] {MODE_RGB565 = 2'd0, MODE_Y = 2'd1, MODE_RAW8 = 2'd2} cap_mode_e;
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} cap_state_e;
  function automatic int calc_aw(input int h, input int v, input int d);
    int n;
    n = (h / d) * (v / d);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ov7670_byte_assembler.sv
// ov7670_byte_assembler: pairs camera bytes into pixels per mode; registered pixel one cycle after the completing byte
module ov7670_byte_assembler import ov7670_cap_pkg::*; #(
  parameter int BYTE_SWAP = 0
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        byte_en_i,
  input  logic        line_start_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  data_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o,
  output logic        phase_o
);
  logic        phase_q, phase_d, phase_cur, valid_q, valid_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] pix_q, pix_d;
  always_comb begin
    phase_cur = line_start_i ? 1'b0 : phase_q;
    phase_d = phase_cur;
    hold_d = hold_q;
    valid_d = 1'b0;
    pix_d = pix_q;
    if (byte_en_i) begin
      if (mode_i == MODE_RAW8) begin
        valid_d = 1'b1;
        pix_d = {8'h00, data_i};
      end else if (!phase_cur) begin
        hold_d = data_i;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        valid_d = 1'b1;
        pix_d = (mode_i == MODE_Y) ? {8'h00, hold_q} :
                (BYTE_SWAP != 0)   ? {data_i, hold_q} : {hold_q, data_i};
      end
    end
  end
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      hold_q <= '0;
      valid_q <= 1'b0;
      pix_q <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q <= hold_d;
      valid_q <= valid_d;
      pix_q <= pix_d;
    end
  end
  assign pix_valid_o = valid_q;
  assign pix_data_o = pix_q;
  assign phase_o = phase_q;
endmodule

// File: rtl/ov7670_capture_gen.sv
// ov7670_capture_gen: OV7670 DVP capture FSM with decimation, linear write addressing,
// frame markers/counter and sticky line/frame error flags
module ov7670_capture_gen import ov7670_cap_pkg::*; #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int DECIM     = 1,
  parameter int BYTE_SWAP = 0,
  parameter int AW        = calc_aw(H_ACTIVE, V_ACTIVE, DECIM),
  parameter int FCW       = 8
) (
  input  logic           pclk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic [1:0]     mode_i,
  input  logic           vsync_i,
  input  logic           href_i,
  input  logic [7:0]     data_i,
  output logic           wren_o,
  output logic [15:0]    data_o,
  output logic [AW-1:0]  addr_o,
  output logic           sof_o,
  output logic           eof_o,
  output logic [FCW-1:0] frame_cnt_o,
  output logic           err_line_o,
  output logic           err_frame_o
);
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  // Counters stop one past the nominal length so overlong lines/frames never wrap into a false match
  localparam logic [XW-1:0] X_LEN = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_LEN = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE + 1);
  cap_state_e     state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           href_q, href_d, vsync_q, vsync_d, full_q, full_d;
  logic [XW-1:0]  x_q, x_d, x_inc;
  logic [YW-1:0]  y_q, y_d, y_inc;
  logic [AW-1:0]  ptr_q, ptr_d, addr_q, addr_d;
  logic           wren_q, wren_d, sof_q, sof_d, eof_q, eof_d;
  logic           errl_q, errl_d, errf_q, errf_d;
  logic [15:0]    data_q, data_d, pix_data;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           href_v, line_start, line_end, vs_rise, vs_fall, pix_valid, phase, wr, frame_full;
  ov7670_byte_assembler #(.BYTE_SWAP(BYTE_SWAP)) u_asm (
    .pclk_i(pclk_i), .rst_i(rst_i), .byte_en_i(href_v), .line_start_i(line_start),
    .mode_i(mode_q), .data_i(data_i), .pix_valid_o(pix_valid), .pix_data_o(pix_data), .phase_o(phase)
  );
  always_comb begin
    href_v = href_i & ~vsync_i & (state_q == ACTIVE);
    line_start = href_v & ~href_q;
    line_end = ~href_v & href_q;
    vs_rise = vsync_i & ~vsync_q;
    vs_fall = ~vsync_i & vsync_q;
    x_inc = (pix_valid && x_q != X_MAX) ? x_q + 1'b1 : x_q;
    y_inc = (line_end && y_q != Y_MAX) ? y_q + 1'b1 : y_q;
    wr = pix_valid && (int'(x_q) % DECIM == 0) && (int'(y_q) % DECIM == 0);
    frame_full = line_end && y_inc == Y_LEN;
    state_d = state_q;
    mode_d = mode_q;
    href_d = href_v;
    vsync_d = vsync_i;
    x_d = line_end ? '0 : x_inc;
    y_d = y_inc;
    ptr_d = ptr_q;
    full_d = full_q;
    wren_d = 1'b0;
    data_d = data_q;
    addr_d = addr_q;
    sof_d = 1'b0;
    eof_d = 1'b0;
    fcnt_d = fcnt_q;
    errl_d = errl_q | (wr & full_q) | (line_end & ((x_inc != X_LEN) | phase));
    errf_d = errf_q;
    if (wr && !full_q) begin
      wren_d = 1'b1;
      data_d = pix_data;
      addr_d = ptr_q;
      sof_d = (ptr_q == '0);
      full_d = &ptr_q;
      ptr_d = (&ptr_q) ? ptr_q : ptr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: state_d = (enable_i && vsync_i) ? SYNC : IDLE;
      SYNC: begin
        mode_d = (mode_i == 2'd3) ? 2'(MODE_RAW8) : mode_i;
        if (vs_fall) begin
          state_d = ACTIVE;
          errl_d = 1'b0;
          errf_d = 1'b0;
          x_d = '0;
          y_d = '0;
          ptr_d = '0;
          full_d = 1'b0;
        end
      end
      ACTIVE: if (frame_full || vs_rise) begin
        state_d = DONE;
        eof_d = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        errf_d = errf_q | ~frame_full;
      end
      DONE: state_d = enable_i ? SYNC : IDLE;
    endcase
  end
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q <= '0;
      href_q <= 1'b0;
      vsync_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      ptr_q <= '0;
      full_q <= 1'b0;
      wren_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      fcnt_q <= '0;
      errl_q <= 1'b0;
      errf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      href_q <= href_d;
      vsync_q <= vsync_d;
      x_q <= x_d;
      y_q <= y_d;
      ptr_q <= ptr_d;
      full_q <= full_d;
      wren_q <= wren_d;
      data_q <= data_d;
      addr_q <= addr_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      fcnt_q <= fcnt_d;
      errl_q <= errl_d;
      errf_q <= errf_d;
    end
  end
  assign wren_o = wren_q;
  assign data_o = data_q;
  assign addr_o = addr_q;
  assign sof_o = sof_q;
  assign eof_o = eof_q;
  assign frame_cnt_o = fcnt_q;
  assign err_line_o = errl_q;
  assign err_frame_o = errf_q;
endmodule

// File: tb/tb_ov7670_capture_gen.sv
// tb_ov7670_capture_gen: directed frames into an 8x4 plain instance and a DECIM=2 byte-swapped instance
module tb_ov7670_capture_gen;
  logic pclk = 1'b0, rst_i = 1'b1, enable_i = 1'b0, vsync_i = 1'b0, href_i = 1'b0, clr = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [7:0] data_i = 8'h00;
  logic wren0, sof0, eof0, errl0, errf0, wren1, sof1, eof1, errl1, errf1;
  logic [15:0] data0, data1;
  logic [4:0] addr0;
  logic [2:0] addr1;
  logic [7:0] fcnt0, fcnt1;
  int n_cmp = 0, n_err = 0, cyc = 0, t_first = 0;
  int nw0 = 0, nw1 = 0, ns0 = 0, ns1 = 0, ne0 = 0, ne1 = 0, sa0 = -1, sa1 = -1, wc0 = 0, wc1 = 0;
  logic [15:0] wd0 [64];
  logic [15:0] wd1 [64];
  int wa0 [64];
  int wa1 [64];
  logic el_pre0, el_pre1, el_s0, el_s1;

  always #5 pclk = ~pclk;

  ov7670_capture_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .BYTE_SWAP(0)) u0 (
    .pclk_i(pclk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i), .vsync_i(vsync_i),
    .href_i(href_i), .data_i(data_i), .wren_o(wren0), .data_o(data0), .addr_o(addr0),
    .sof_o(sof0), .eof_o(eof0), .frame_cnt_o(fcnt0), .err_line_o(errl0), .err_frame_o(errf0));
  ov7670_capture_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .BYTE_SWAP(1)) u1 (
    .pclk_i(pclk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i), .vsync_i(vsync_i),
    .href_i(href_i), .data_i(data_i), .wren_o(wren1), .data_o(data1), .addr_o(addr1),
    .sof_o(sof1), .eof_o(eof1), .frame_cnt_o(fcnt1), .err_line_o(errl1), .err_frame_o(errf1));

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (clr) begin
      nw0 <= 0; nw1 <= 0; ns0 <= 0; ns1 <= 0; ne0 <= 0; ne1 <= 0; sa0 <= -1; sa1 <= -1;
    end else begin
      if (wren0) begin
        if (nw0 == 0) wc0 <= cyc;
        if (nw0 < 64) begin wd0[nw0] <= data0; wa0[nw0] <= int'(addr0); end
        nw0 <= nw0 + 1;
      end
      if (wren1) begin
        if (nw1 == 0) wc1 <= cyc;
        if (nw1 < 64) begin wd1[nw1] <= data1; wa1[nw1] <= int'(addr1); end
        nw1 <= nw1 + 1;
      end
      if (sof0) begin ns0 <= ns0 + 1; sa0 <= wren0 ? int'(addr0) : -1; end
      if (sof1) begin ns1 <= ns1 + 1; sa1 <= wren1 ? int'(addr1) : -1; end
      if (eof0) ne0 <= ne0 + 1;
      if (eof1) ne1 <= ne1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  function automatic logic [7:0] byte_of(input logic [1:0] m, input int l, input int j);
    if (m == 2'd0) return j[0] ? 8'hCD : 8'hAB;
    if (m == 2'd1) return j[0] ? 8'h80 : 8'(16 + j / 2);
    return 8'(l * 16 + j);
  endfunction

  // Expected k-th written pixel of an 8x4 frame decimated by d (d=2 instance is byte-swapped)
  function automatic logic [15:0] exp_pix(input logic [1:0] m, input int d, input int k);
    int x, l;
    x = d * (k % (8 / d));
    l = d * (k / (8 / d));
    if (m == 2'd0) return (d == 1) ? 16'hABCD : 16'hCDAB;
    if (m == 2'd1) return 16'(16 + x);
    return 16'(l * 16 + x);
  endfunction

  task automatic frame(input logic [1:0] m, input int nlines, input int bad_line, input int bad_bytes);
    int bpl;
    bpl = (m == 2'd2) ? 8 : 16;
    mode_i = m; vsync_i = 1'b1; clr = 1'b1; tick(1); clr = 1'b0; tick(2);
    el_pre0 = errl0; el_pre1 = errl1;
    vsync_i = 1'b0; tick(3);
    el_s0 = errl0; el_s1 = errl1;
    for (int l = 0; l < nlines; l++) begin
      for (int j = 0; j < ((l == bad_line) ? bad_bytes : bpl); j++) begin
        href_i = 1'b1; data_i = byte_of(m, l, j); tick(1);
        if (l == 0 && j == ((m == 2'd2) ? 0 : 1)) t_first = cyc;
      end
      href_i = 1'b0; data_i = 8'h00; tick(4);
    end
    vsync_i = 1'b1; tick(4);
  endtask

  task automatic check_frame(input string tag, input logic [1:0] m, input int n0, input int n1,
                             input int fc, input logic el, input logic ef, input logic dchk);
    chk({tag, "_nw0"}, nw0, n0);
    chk({tag, "_nw1"}, nw1, n1);
    chk({tag, "_eof0"}, ne0, 1);
    chk({tag, "_eof1"}, ne1, 1);
    chk({tag, "_fcnt0"}, fcnt0, fc);
    chk({tag, "_fcnt1"}, fcnt1, fc);
    chk({tag, "_errl0"}, errl0, el);
    chk({tag, "_errl1"}, errl1, el);
    chk({tag, "_errf0"}, errf0, ef);
    chk({tag, "_errf1"}, errf1, ef);
    if (dchk) begin
      chk({tag, "_sof0"}, ns0, 1);
      chk({tag, "_sofaddr0"}, sa0, 0);
      chk({tag, "_sof1"}, ns1, 1);
      chk({tag, "_sofaddr1"}, sa1, 0);
      chk({tag, "_lat0"}, wc0, t_first + 1);
      chk({tag, "_lat1"}, wc1, t_first + 1);
      for (int k = 0; k < n0; k++) begin
        chk({tag, "_data0"}, wd0[k], exp_pix(m, 1, k));
        chk({tag, "_addr0"}, wa0[k], k);
      end
      for (int k = 0; k < n1; k++) begin
        chk({tag, "_data1"}, wd1[k], exp_pix(m, 2, k));
        chk({tag, "_addr1"}, wa1[k], k);
      end
    end
  endtask

  initial begin
    tick(2);
    chk("rst_data", data0, 0);
    chk("rst_ctl0", {wren0, sof0, eof0, errl0, errf0, addr0, fcnt0}, 0);
    chk("rst_ctl1", {wren1, sof1, eof1, errl1, errf1, addr1, fcnt1, data1}, 0);
    rst_i = 1'b0; enable_i = 1'b1; vsync_i = 1'b1; tick(2);
    frame(2'd0, 4, -1, 0);
    check_frame("rgb", 2'd0, 32, 8, 1, 1'b0, 1'b0, 1'b1);
    frame(2'd1, 4, -1, 0);
    check_frame("yuv", 2'd1, 32, 8, 2, 1'b0, 1'b0, 1'b1);
    frame(2'd2, 4, -1, 0);
    check_frame("raw", 2'd2, 32, 8, 3, 1'b0, 1'b0, 1'b1);
    frame(2'd2, 4, 1, 7);
    check_frame("rawshort", 2'd2, 31, 8, 4, 1'b1, 1'b0, 1'b0);
    frame(2'd0, 4, 1, 15);
    check_frame("rgbodd", 2'd0, 31, 8, 5, 1'b1, 1'b0, 1'b0);
    chk("errl_held0", el_pre0, 1);
    chk("errl_held1", el_pre1, 1);
    chk("errl_clr0", el_s0, 0);
    chk("errl_clr1", el_s1, 0);
    frame(2'd0, 2, -1, 0);
    check_frame("early", 2'd0, 16, 4, 6, 1'b0, 1'b1, 1'b1);
    frame(2'd0, 4, -1, 0);
    check_frame("clean", 2'd0, 32, 8, 7, 1'b0, 1'b0, 1'b1);
    mode_i = 2'd0; vsync_i = 1'b1; tick(3); vsync_i = 1'b0; tick(3);
    for (int j = 0; j < 5; j++) begin href_i = 1'b1; data_i = byte_of(2'd0, 0, j); tick(1); end
    rst_i = 1'b1; #1;
    chk("midrst_data", data0, 0);
    chk("midrst_ctl0", {wren0, sof0, eof0, errl0, errf0, addr0, fcnt0}, 0);
    chk("midrst_ctl1", {wren1, sof1, eof1, errl1, errf1, addr1, fcnt1}, 0);
    tick(2); rst_i = 1'b0;
    clr = 1'b1; tick(1); clr = 1'b0;
    for (int j = 5; j < 32; j++) begin href_i = 1'b1; data_i = byte_of(2'd0, 0, j); tick(1); end
    href_i = 1'b0; tick(6);
    chk("idle_nw0", nw0, 0);
    chk("idle_nw1", nw1, 0);
    chk("idle_eof0", ne0, 0);
    chk("idle_fcnt0", fcnt0, 0);
    frame(2'd0, 4, -1, 0);
    check_frame("resume", 2'd0, 32, 8, 1, 1'b0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
